// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned ARB_N     = 8;
  localparam int unsigned ARB_IDX_W = 3;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  typedef logic [ARB_N-1:0]     arb_vec_t;
  typedef logic [ARB_IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle for rr_arbiter_8; the arbiter takes the slave side.
// The lock signal exists only when GRANT_LOCK_EN is defined.
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic     en;
  arb_vec_t req;
  logic     out_ready;
`ifdef GRANT_LOCK_EN
  logic     lock;
`endif
  arb_vec_t gnt;
  arb_idx_t gnt_idx;
  logic     out_valid;

  modport slave (
    input  en,
    input  req,
    input  out_ready,
`ifdef GRANT_LOCK_EN
    input  lock,
`endif
    output gnt,
    output gnt_idx,
    output out_valid
  );

  modport master (
    output en,
    output req,
    output out_ready,
`ifdef GRANT_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  gnt_idx,
    input  out_valid
  );

endinterface

// File: rtl/rr_arbiter_8_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping 7->0.
module rr_pick
  import arb_pkg::*;
(
  input  arb_vec_t i_req,
  input  arb_idx_t i_ptr,
  output logic     o_any,
  output arb_vec_t o_pick_oh,
  output arb_idx_t o_pick_idx
);

  arb_vec_t w_rot;
  arb_vec_t w_low_oh;
  arb_idx_t w_low_idx;

  // Rotate so that position i_ptr lands on bit 0.
  assign w_rot = arb_vec_t'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_low_oh  = '0;
    w_low_idx = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_low_oh  = arb_vec_t'(1) << i;
        w_low_idx = arb_idx_t'(i);
      end
    end
  end

  assign o_any      = |i_req;
  assign o_pick_oh  = arb_vec_t'(({w_low_oh, w_low_oh} << i_ptr) >> ARB_N);
  assign o_pick_idx = w_low_idx + i_ptr;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter with registered one-hot grant held on a valid/ready handshake.
// Optional GRANT_LOCK_EN adds a lock input that re-grants the same requester for bursts.
module rr_arbiter_8
  import arb_pkg::*;
(
  input logic           i_clk,
  input logic           i_rst,
  rr_arbiter_8_if.slave bus
);

  arb_state_t r_state;
  arb_idx_t   r_ptr;
  arb_vec_t   r_gnt;
  arb_idx_t   r_gnt_idx;
  logic       r_out_valid;

  logic     w_accept;
  logic     w_lock_hit;
  logic     w_any;
  arb_idx_t w_ptr_inc;
  arb_idx_t w_pick_ptr;
  arb_vec_t w_pick_oh;
  arb_idx_t w_pick_idx;

  assign w_accept  = r_out_valid & bus.out_ready;
  assign w_ptr_inc = r_gnt_idx + 3'd1;
  // In GRANT the search for a back-to-back grant starts from the post-accept pointer.
  assign w_pick_ptr = (r_state == ARB_GRANT) ? w_ptr_inc : r_ptr;

`ifdef GRANT_LOCK_EN
  assign w_lock_hit = bus.lock & bus.en & bus.req[r_gnt_idx];
`else
  assign w_lock_hit = 1'b0;
`endif

  rr_pick u_pick (
    .i_req      (bus.req),
    .i_ptr      (w_pick_ptr),
    .o_any      (w_any),
    .o_pick_oh  (w_pick_oh),
    .o_pick_idx (w_pick_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (bus.en && w_any) begin
            r_gnt       <= w_pick_oh;
            r_gnt_idx   <= w_pick_idx;
            r_out_valid <= 1'b1;
            r_state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A lock hit keeps gnt, gnt_idx and ptr exactly as they are.
          if (w_accept && !w_lock_hit) begin
            r_ptr <= w_ptr_inc;
            if (bus.en && w_any) begin
              r_gnt     <= w_pick_oh;
              r_gnt_idx <= w_pick_idx;
            end else begin
              r_gnt       <= '0;
              r_gnt_idx   <= '0;
              r_out_valid <= 1'b0;
              r_state     <= ARB_IDLE;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8; lock scenario runs when GRANT_LOCK_EN is set.
module tb_rr_arbiter_8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [7:0] g,
                            input logic [2:0] idx);
    checks++;
    if (bus.out_valid !== v || bus.gnt !== g || bus.gnt_idx !== idx) begin
      failures++;
      $display("FAIL %s: got valid=%b gnt=%h idx=%0d, want valid=%b gnt=%h idx=%0d",
               name, bus.out_valid, bus.gnt, bus.gnt_idx, v, g, idx);
    end
  endtask

  task automatic do_reset(input logic [7:0] req_v);
    rst           = 1'b1;
    bus.en        = 1'b1;
    bus.req       = req_v;
    bus.out_ready = 1'b0;
`ifdef GRANT_LOCK_EN
    bus.lock      = 1'b0;
`endif
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'hFF);
    rst = 1'b1;
    step();
    expect_out("reset_hold", 1'b0, 8'h00, 3'd0);
    rst = 1'b0;
    step();
    expect_out("first_grant", 1'b1, 8'h01, 3'd0);
  endtask

  task automatic test_rotation();
    logic [2:0] want;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      want = 3'(k % 8);
      expect_out($sformatf("rotate_%0d", k), 1'b1, 8'h01 << want, want);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset(8'h24);
    step();
    expect_out("bp_first", 1'b1, 8'h04, 3'd2);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) bus.req = 8'h01;
      step();
      expect_out($sformatf("bp_hold_%0d", k), 1'b1, 8'h04, 3'd2);
    end
    bus.out_ready = 1'b1;
    step();
    expect_out("bp_release", 1'b1, 8'h01, 3'd0);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_sparse_wrap();
    do_reset(8'h40);
    step();
    expect_out("wrap_first", 1'b1, 8'h40, 3'd6);
    bus.req       = 8'h41;
    bus.out_ready = 1'b1;
    step();
    expect_out("wrap_next", 1'b1, 8'h01, 3'd0);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_enable_reset();
    do_reset(8'h08);
    step();
    expect_out("en_first", 1'b1, 8'h08, 3'd3);
    bus.en = 1'b0;
    step();
    expect_out("en_low_hold", 1'b1, 8'h08, 3'd3);
    bus.out_ready = 1'b1;
    step();
    expect_out("en_low_accept", 1'b0, 8'h00, 3'd0);
    bus.out_ready = 1'b0;
    step();
    expect_out("en_low_idle", 1'b0, 8'h00, 3'd0);
    bus.en  = 1'b1;
    bus.req = 8'hFF;
    step();
    expect_out("ptr_advanced", 1'b1, 8'h10, 3'd4);
    rst = 1'b1;
    step();
    expect_out("mid_reset", 1'b0, 8'h00, 3'd0);
    rst = 1'b0;
    step();
    expect_out("post_reset_ptr0", 1'b1, 8'h01, 3'd0);
  endtask

`ifdef GRANT_LOCK_EN
  task automatic test_lock();
    do_reset(8'h0A);
    bus.lock = 1'b1;
    step();
    expect_out("lock_first", 1'b1, 8'h02, 3'd1);
    bus.out_ready = 1'b1;
    step();
    expect_out("lock_regrant", 1'b1, 8'h02, 3'd1);
    bus.lock = 1'b0;
    step();
    expect_out("lock_release", 1'b1, 8'h08, 3'd3);
    bus.out_ready = 1'b0;
  endtask
`endif

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.req       = 8'h00;
    bus.out_ready = 1'b0;
`ifdef GRANT_LOCK_EN
    bus.lock      = 1'b0;
`endif
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse_wrap();
    test_enable_reset();
`ifdef GRANT_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
